// File: rtl/io_pattern_tx.sv
// io_pattern_tx: drives a self-checking pattern onto the lower user pads.
// On an accepted start it drives 1..N, then all-ones, then all-zeros, and
// holds each value for hold_cycles+1 clocks. It then pulses done.
//
// Ports:
//   clock        - single clock, posedge
//   resetb       - asynchronous active-low reset
//   start        - one-cycle request, accepted only when idle
//   abort        - one-cycle request, terminates an active sequence
//   hold_cycles  - per-step hold minus one, latched on start
//   count_last   - final count value N, latched on start
//   io_out       - pad output data
//   io_oeb       - pad output-enable-bar (0 = driving)
//   busy         - high while counting / ones / zeros
//   done         - one-cycle pulse on normal completion
module io_pattern_tx #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HOLD_W = 16
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [WIDTH-1:0]  count_last,
    output logic [WIDTH-1:0]  io_out,
    output logic [WIDTH-1:0]  io_oeb,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_ONES  = 3'd2;
    localparam logic [2:0] S_ZEROS = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [WIDTH-1:0]  step_q,  step_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [HOLD_W-1:0] h_q,     h_d;
    logic [WIDTH-1:0]  n_q,     n_d;
    logic              armed_q, armed_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    // State and datapath registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            hold_q  <= '0;
            h_q     <= '0;
            n_q     <= '0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            h_q     <= h_d;
            n_q     <= n_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        h_d     = h_q;
        n_d     = n_q;
        armed_d = armed_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous abort here; abort is a no-op
                if (start) begin
                    h_d     = hold_cycles;
                    n_d     = count_last;
                    hold_d  = hold_cycles;
                    armed_d = 1'b1;
                    busy_d  = 1'b1;
                    if (count_last != '0) begin
                        state_d = S_COUNT;
                        step_d  = WIDTH'(1);
                    end else begin
                        state_d = S_ONES;
                        step_d  = '1;
                    end
                end
            end

            S_COUNT, S_ONES, S_ZEROS: begin
                if (abort) begin
                    // abort beats a same-cycle hold expiry; armed stays set
                    state_d = S_IDLE;
                    step_d  = '0;
                    hold_d  = '0;
                    busy_d  = 1'b0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d = h_q;
                    if (state_q == S_COUNT) begin
                        // compare before increment so N = all-ones never wraps
                        if (step_q == n_q) begin
                            state_d = S_ONES;
                            step_d  = '1;
                        end else begin
                            step_d = step_q + WIDTH'(1);
                        end
                    end else if (state_q == S_ONES) begin
                        state_d = S_ZEROS;
                        step_d  = '0;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                step_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign io_out = step_q;
    assign io_oeb = {WIDTH{~armed_q}};
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_io_pattern_tx.sv
// Bench for io_pattern_tx: a per-cycle expectation queue is expanded from
// each accepted start (N count values, ones, zeros, a done cycle) and
// compared with the pads every cycle on the falling edge.
module tb_io_pattern_tx;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HOLD_W = 16;

    logic              clock = 1'b0;
    logic              resetb;
    logic              start;
    logic              abort;
    logic [HOLD_W-1:0] hold_cycles;
    logic [WIDTH-1:0]  count_last;
    logic [WIDTH-1:0]  io_out;
    logic [WIDTH-1:0]  io_oeb;
    logic              busy;
    logic              done;

    io_pattern_tx #(.WIDTH(WIDTH), .HOLD_W(HOLD_W)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .start       (start),
        .abort       (abort),
        .hold_cycles (hold_cycles),
        .count_last  (count_last),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             busy;
        logic             done;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    logic exp_armed;
    int   total = 0;
    int   bad   = 0;
    int   done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur       = '0;
        exp_armed = 1'b0;
    endtask

    // Expected cycle trace of one full sequence
    task automatic build_seq(input int unsigned h, input int unsigned n);
        rec_t r;
        for (int unsigned k = 1; k <= n; k++)
            for (int unsigned j = 0; j <= h; j++) begin
                r = '0; r.out = WIDTH'(k); r.busy = 1'b1; q.push_back(r);
            end
        for (int unsigned j = 0; j <= h; j++) begin
            r = '0; r.out = '1; r.busy = 1'b1; q.push_back(r);
        end
        for (int unsigned j = 0; j <= h; j++) begin
            r = '0; r.busy = 1'b1; q.push_back(r);
        end
        r = '0; r.done = 1'b1; q.push_back(r);
    endtask

    // Model behaviour at one rising edge, given the inputs held across it
    task automatic model_edge();
        if (cur.busy && abort) begin
            q.delete();
            cur = '0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.done) begin
            cur = '0;
        end else if (start) begin
            build_seq(int'(hold_cycles), int'(count_last));
            cur       = q.pop_front();
            exp_armed = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("io_out", 32'(io_out), 32'(cur.out));
        chk("io_oeb", 32'(io_oeb), exp_armed ? 32'h0 : 32'(WIDTH'('1)));
        chk("busy",   32'(busy),   32'(cur.busy));
        chk("done",   32'(done),   32'(cur.done));
        if (done) done_seen++;
    endtask

    // Drive one cycle's inputs, let the edge happen, check on the falling edge
    task automatic step(input logic s, input logic a, input logic [HOLD_W-1:0] h,
                        input logic [WIDTH-1:0] n);
        start = s; abort = a; hold_cycles = h; count_last = n;
        @(posedge clock);
        if (resetb) model_edge();
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        hold_cycles = HOLD_W'($urandom); count_last = WIDTH'($urandom);
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, HOLD_W'($urandom), WIDTH'($urandom));
    endtask

    initial begin
        int   d0;
        logic found;
        resetb = 1'b0; start = 1'b0; abort = 1'b0;
        hold_cycles = '0; count_last = '0;
        model_reset();
        #1 check_all();
        @(negedge clock); @(negedge clock);
        resetb = 1'b1;
        idle(2);

        // H=0, N=10: one clock per value, done 12 clocks after first 01
        step(1'b1, 1'b0, 16'd0, 8'h0A);
        idle(14);

        // H=3, N=3: each value held four clocks
        step(1'b1, 1'b0, 16'd3, 8'h03);
        idle(22);

        // N=0, H=1: only ones then zeros
        step(1'b1, 1'b0, 16'd1, 8'h00);
        idle(6);

        // start re-pulsed mid-count is ignored, exactly one done
        d0 = done_seen;
        step(1'b1, 1'b0, 16'd1, 8'h05);
        idle(3);
        step(1'b1, 1'b0, 16'd0, 8'h02);
        idle(16);
        chk("one_done", 32'(done_seen - d0), 32'd1);

        // abort while io_out == 05, then a clean full run
        d0 = done_seen;
        found = 1'b0;
        step(1'b1, 1'b0, 16'd0, 8'h0A);
        for (int i = 0; i < 40 && !found; i++) begin
            if (io_out == 8'h05) found = 1'b1;
            else idle(1);
        end
        chk("wait_05", 32'(found), 32'd1);
        step(1'b0, 1'b1, 16'd0, 8'h00);
        idle(4);
        chk("no_done_abort", 32'(done_seen - d0), 32'd0);
        step(1'b1, 1'b1, 16'd1, 8'h02);
        idle(12);

        // async reset while io_out == FF
        step(1'b1, 1'b0, 16'd3, 8'h00);
        chk("pre_rst_ff", 32'(io_out), 32'hFF);
        #2 resetb = 1'b0;
        #1 model_reset();
        check_all();
        idle(2);
        resetb = 1'b1;
        idle(4);
        step(1'b1, 1'b0, 16'd0, 8'h01);
        idle(5);

        // N = all-ones: no wrap before ones
        step(1'b1, 1'b0, 16'd0, 8'hFF);
        idle(262);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 8) == 0, ($urandom % 40) == 0,
                 HOLD_W'($urandom % 4), WIDTH'($urandom % 16));
        end
        idle(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
